// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory fill responder.
// Block geometry here matches the 16-byte cache line used by the I/D-caches.
package mem_fill_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BURST_BEATS = 8;
  localparam int BEAT_CNT_W  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mem_fill_state_e;

  // One entry of the response pipeline.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] addr;
    logic [15:0] data;
  } fill_beat_t;

  function automatic logic [15:0] block_base(input logic [15:0] a);
    return a & ~16'(BLOCK_BYTES - 1);
  endfunction

  // Beats step by one 16-bit word and never carry out of the block.
  function automatic logic [15:0] beat_addr(input logic [15:0] base,
                                            input logic [BEAT_CNT_W-1:0] beat);
    return {base[15:4], beat, 1'b0};
  endfunction

endpackage

// File: rtl/mem_fill_delay_line.sv
// Fixed-latency response pipeline: LATENCY stages of {valid, last, addr, data}.
// The tail stage drives the response ports, forced to zero when not valid.
module mem_fill_delay_line
  import mem_fill_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  fill_beat_t  beat_in,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [15:0] data_addr,
  output logic        data_last
);

  fill_beat_t stage [LATENCY];
  fill_beat_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= beat_in;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tail       = stage[LATENCY-1];
  assign data_valid = tail.valid;
  assign data_out   = tail.valid ? tail.data : 16'h0000;
  assign data_addr  = tail.valid ? tail.addr : 16'h0000;
  assign data_last  = tail.valid ? tail.last : 1'b0;

endmodule

// File: rtl/mem_fill_responder.sv
// Memory-side responder for cache fill/writeback traffic: word store, accept
// logic and, when MEM_FILL_BURST_EN is defined, an 8-beat block-read FSM.
module mem_fill_responder
  import mem_fill_pkg::*;
#(
  parameter int LATENCY        = 4,
  parameter int WORD_ADDR_BITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            wr,
  input  logic [15:0]     addr,
  input  logic [15:0]     data_in,
`ifdef MEM_FILL_BURST_EN
  input  logic            burst,
`endif
  output logic            ready,
  output logic [15:0]     data_out,
  output logic [15:0]     data_addr,
  output logic            data_valid,
  output logic            data_last,
  output mem_fill_state_e dbg_state
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  // Handshake: a request is taken on a rising edge when enable and ready are
  // both high and rst is low; anything else leaves store and pipeline untouched.
  logic        accept;
  logic [15:0] rd_addr;
  fill_beat_t  issue;
  logic [15:0] store [DEPTH];
  logic        unused_addr_lsb;

  assign accept          = enable & ready & ~rst;
  assign unused_addr_lsb = addr[0];

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      store[addr[WORD_ADDR_BITS:1]] <= data_in;
    end
  end

`ifdef MEM_FILL_BURST_EN
  mem_fill_state_e       state;
  logic [15:0]           base_q;
  logic [BEAT_CNT_W-1:0] beat_q;

  assign ready     = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= 16'h0000;
      beat_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !wr && burst) begin
            base_q <= block_base(addr);
            beat_q <= BEAT_CNT_W'(1);
            state  <= BURST;
          end
        end
        BURST: begin
          beat_q <= beat_q + BEAT_CNT_W'(1);
          if (beat_q == BEAT_CNT_W'(BURST_BEATS - 1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    issue   = '0;
    rd_addr = {addr[15:1], 1'b0};
    if (state == BURST) begin
      rd_addr     = beat_addr(base_q, beat_q);
      issue.valid = 1'b1;
      issue.last  = (beat_q == BEAT_CNT_W'(BURST_BEATS - 1));
    end else if (accept && !wr) begin
      issue.valid = 1'b1;
      if (burst) begin
        rd_addr    = block_base(addr);
        issue.last = 1'b0;
      end else begin
        issue.last = 1'b1;
      end
    end
    issue.addr = rd_addr;
    // Data is captured now, so later writes cannot disturb in-flight reads.
    issue.data = store[rd_addr[WORD_ADDR_BITS:1]];
  end
`else
  assign ready     = 1'b1;
  assign dbg_state = IDLE;

  always_comb begin
    issue       = '0;
    rd_addr     = {addr[15:1], 1'b0};
    issue.valid = accept & ~wr;
    issue.last  = 1'b1;
    issue.addr  = rd_addr;
    issue.data  = store[rd_addr[WORD_ADDR_BITS:1]];
  end
`endif

  mem_fill_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk        (clk),
    .rst        (rst),
    .beat_in    (issue),
    .data_valid (data_valid),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .data_last  (data_last)
  );

endmodule

// File: tb/tb_mem_fill_responder.sv
// Self-checking bench for mem_fill_responder: directed cases plus random
// traffic scored against a cycle-indexed expectation queue.
module tb_mem_fill_responder;
  import mem_fill_pkg::*;

  localparam int LAT    = 4;
  localparam int WAB    = 13;
  localparam int NWORDS = 1 << WAB;
`ifdef MEM_FILL_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            wr;
  logic [15:0]     addr;
  logic [15:0]     data_in;
  logic            burst;
  logic            ready;
  logic [15:0]     data_out;
  logic [15:0]     data_addr;
  logic            data_valid;
  logic            data_last;
  mem_fill_state_e dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_fill_responder #(
    .LATENCY        (LAT),
    .WORD_ADDR_BITS (WAB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
`ifdef MEM_FILL_BURST_EN
    .burst      (burst),
`endif
    .ready      (ready),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .data_valid (data_valid),
    .data_last  (data_last),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] mem_m [NWORDS];
  logic [32:0] exp_q [$];   // {last, addr, data}
  int          due_q [$];   // edge after which the entry is visible
  int          cyc           = 0;
  int          blocked_until = 0;
  int          n_vec         = 0;
  int          n_err         = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a >> 1) % NWORDS;
  endfunction

  task automatic check_outputs();
    logic [32:0] e;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check_eq("data_valid", 32'(data_valid), 32'd1);
      check_eq("data_out", 32'(data_out), 32'(e[15:0]));
      check_eq("data_addr", 32'(data_addr), 32'(e[31:16]));
      check_eq("data_last", 32'(data_last), 32'(e[32]));
    end else begin
      check_eq("idle_valid", 32'(data_valid), 32'd0);
      check_eq("idle_out", 32'(data_out), 32'd0);
      check_eq("idle_addr", 32'(data_addr), 32'd0);
      check_eq("idle_last", 32'(data_last), 32'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies one cycle of inputs, predicts the
  // outcome of the next rising edge, then checks outputs after that edge.
  task automatic step(input bit en, input bit w, input logic [15:0] a,
                      input logic [15:0] d, input bit b, input bit r);
    bit          exp_ready;
    bit          do_burst;
    int          e_edge;
    logic [15:0] base;
    logic [15:0] ba;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    burst   = b;
    rst     = r;
    exp_ready = (cyc >= blocked_until);
    check_eq("ready", 32'(ready), 32'(exp_ready));
    do_burst = b && BURST_BUILD;
    e_edge   = cyc + 1;
    if (r) begin
      due_q.delete();
      exp_q.delete();
      blocked_until = 0;
    end else if (en && exp_ready) begin
      if (w) begin
        mem_m[widx(a)] = d;
      end else if (do_burst) begin
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
          ba = 16'(base + 16'(2 * k));
          due_q.push_back(e_edge + k + LAT - 1);
          exp_q.push_back({(k == 7), ba, mem_m[widx(ba)]});
        end
        blocked_until = e_edge + 7;
      end else begin
        due_q.push_back(e_edge + LAT - 1);
        exp_q.push_back({1'b1, a & 16'hFFFE, mem_m[widx(a)]});
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 16'h0000, 0, 0);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    step(1, 1, a, d, 0, 0);
  endtask

  task automatic rd_word(input logic [15:0] a);
    step(1, 0, a, 16'h0000, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra;
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0; burst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_out", 32'(data_out), 32'd0);
    check_eq("rst_addr", 32'(data_addr), 32'd0);
    check_eq("rst_last", 32'(data_last), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    cyc = 0;

    // Write then immediate read-back.
    wr_word(16'h0010, 16'h1234);
    rd_word(16'h0010);
    idle(LAT + 1);

    // Back-to-back reads.
    wr_word(16'h0000, 16'h00A0);
    wr_word(16'h0002, 16'h00A1);
    wr_word(16'h0004, 16'h00A2);
    rd_word(16'h0000);
    rd_word(16'h0002);
    rd_word(16'h0004);
    idle(LAT + 1);

    // A write behind an in-flight read does not change its data.
    wr_word(16'h0020, 16'h1111);
    rd_word(16'h0020);
    wr_word(16'h0020, 16'h2222);
    idle(LAT);
    rd_word(16'h0020);
    idle(LAT + 1);

    // Address aliasing above WORD_ADDR_BITS, and odd byte address.
    rd_word(16'h4010);
    rd_word(16'h0011);
    idle(LAT + 1);

    // Reset with reads in flight; committed writes survive.
    wr_word(16'h0060, 16'h5A5A);
    rd_word(16'h0060);
    rd_word(16'h0010);
    step(0, 0, 16'h0000, 16'h0000, 0, 1);
    idle(LAT + 1);
    rd_word(16'h0060);
    idle(LAT + 1);

    if (BURST_BUILD) begin
      for (int k = 0; k < 8; k++) wr_word(16'(16'h0040 + 2 * k), 16'(16'h00B0 + k));
      step(1, 0, 16'h0046, 16'h0000, 1, 0);
      // Requests while busy must be ignored.
      for (int k = 0; k < 7; k++) step(1, 1, 16'h0040, 16'hDEAD, 0, 0);
      rd_word(16'h0040);
      idle(LAT + 8);

      // Reset two cycles into a burst.
      step(1, 0, 16'h004A, 16'h0000, 1, 0);
      idle(2);
      step(0, 0, 16'h0000, 16'h0000, 0, 1);
      rd_word(16'h0060);
      idle(LAT + 8);
    end

    // Random traffic over a 64-word pool, with alias bits and resets.
    for (int i = 0; i < 64; i++) wr_word(16'(2 * i), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      ra = 16'(($urandom_range(0, 3) << 14) | ($urandom_range(0, 63) << 1)
               | $urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ra,
           16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    end
    idle(LAT + 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
